grn_attractor_worker: RTL and testbench

- Worker block that receives one initial network configuration from the dispatcher and iterates the Boolean network update function from that configuration.
- Uses Brent's algorithm to find the attractor cycle length (lambda) and the transient length (mu), then reports both back to the dispatcher.
- It is the responder side of the dispatcher's start/done handshake; the dispatcher instantiates BLOCKS_NUMBER copies.

---
 rtl/grn_pkg.sv | 22 ++
 rtl/grn_next_state.sv | 36 +++
 rtl/grn_attractor_worker.sv | 153 +++++++++++++++
 tb/tb_grn_attractor_worker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/grn_pkg.sv
// Shared types for the gene-regulatory-network attractor search: rule select,
// worker FSM states and the default network width.
package grn_pkg;

    localparam int unsigned GRN_VECTOR_SIZE = 69;

    typedef enum logic [1:0] {
        RULE_RULE90,
        RULE_ROTL,
        RULE_NET
    } t_rule;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAM,
        ADV,
        MU,
        DONE
    } t_wstate;

endpackage

// File: rtl/grn_next_state.sv
// Purely combinational Boolean network update f(x), selected at elaboration time by RULE.
module grn_next_state
    import grn_pkg::*;
#(
    parameter int unsigned VECTOR_SIZE = GRN_VECTOR_SIZE,
    parameter t_rule       RULE        = RULE_NET
) (
    input  logic [VECTOR_SIZE-1:0] i_state,
    output logic [VECTOR_SIZE-1:0] o_next
);

    logic [VECTOR_SIZE-1:0] w_r90;
    logic [VECTOR_SIZE-1:0] w_rotl;
    logic [VECTOR_SIZE-1:0] w_net;

    for (genvar i = 0; i < VECTOR_SIZE; i++) begin : g_bit
        localparam int unsigned Prev = (i + VECTOR_SIZE - 1) % VECTOR_SIZE;
        localparam int unsigned Nxt  = (i + 1) % VECTOR_SIZE;
        assign w_r90[i] = i_state[Prev] ^ i_state[Nxt];
        // Node switches on when activated by its left neighbour and not repressed by its right
        // one, and latches while its right neighbour stays active.
        assign w_net[i] = (i_state[Prev] & ~i_state[Nxt]) | (i_state[i] & i_state[Nxt]);
    end

    assign w_rotl = {i_state[VECTOR_SIZE-2:0], i_state[VECTOR_SIZE-1]};

    always_comb begin
        o_next = w_net;
        case (RULE)
            RULE_RULE90: o_next = w_r90;
            RULE_ROTL:   o_next = w_rotl;
            default:     o_next = w_net;
        endcase
    end

endmodule

// File: rtl/grn_attractor_worker.sv
// Finds attractor length (lambda) and transient length (mu) of the orbit starting at conf_in
// using Brent's cycle detection, with a watchdog on the number of iteration cycles.
module grn_attractor_worker
    import grn_pkg::*;
#(
    parameter int unsigned VECTOR_SIZE = GRN_VECTOR_SIZE,
    parameter t_rule       RULE        = RULE_NET,
    parameter int unsigned MAX_STEPS   = 2**20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_in,
    input  logic                   done_in,
    input  logic [VECTOR_SIZE-1:0] conf_in,
    output logic [VECTOR_SIZE-1:0] conf_out,
    output logic [31:0]            length_out,
    output logic [31:0]            transient_out,
    output logic                   done_out,
    output logic                   busy_out,
    output logic                   timeout_out
);

    t_wstate                r_state;
    logic [VECTOR_SIZE-1:0] r_x0;
    logic [VECTOR_SIZE-1:0] r_tort;
    logic [VECTOR_SIZE-1:0] r_hare;
    logic [31:0]            r_power;
    logic [31:0]            r_lam;
    logic [31:0]            r_mu;
    logic [31:0]            r_adv_cnt;
    logic [31:0]            r_steps;

    logic [VECTOR_SIZE-1:0] w_a_in;
    logic [VECTOR_SIZE-1:0] w_next_a;
    logic [VECTOR_SIZE-1:0] w_next_b;
    logic                   w_accept;
    logic                   w_iter;

    // Instance A serves f(x0) in LOAD and f(tort) in MU; instance B always advances hare.
    assign w_a_in   = (r_state == LOAD) ? r_x0 : r_tort;
    assign w_accept = start_in && ((r_state == IDLE) || (r_state == DONE));
    assign w_iter   = (r_state == LAM) || (r_state == ADV) || (r_state == MU);

    grn_next_state #(
        .VECTOR_SIZE (VECTOR_SIZE),
        .RULE        (RULE)
    ) u_next_a (
        .i_state (w_a_in),
        .o_next  (w_next_a)
    );

    grn_next_state #(
        .VECTOR_SIZE (VECTOR_SIZE),
        .RULE        (RULE)
    ) u_next_b (
        .i_state (r_hare),
        .o_next  (w_next_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_x0          <= '0;
            r_tort        <= '0;
            r_hare        <= '0;
            r_power       <= '0;
            r_lam         <= '0;
            r_mu          <= '0;
            r_adv_cnt     <= '0;
            r_steps       <= '0;
            conf_out      <= '0;
            length_out    <= '0;
            transient_out <= '0;
            done_out      <= 1'b0;
            busy_out      <= 1'b0;
            timeout_out   <= 1'b0;
        end else if (w_accept) begin
            r_x0        <= conf_in;
            conf_out    <= conf_in;
            r_steps     <= '0;
            done_out    <= 1'b0;
            timeout_out <= 1'b0;
            busy_out    <= 1'b1;
            r_state     <= LOAD;
        end else if (w_iter && (r_steps == MAX_STEPS)) begin
            length_out    <= '0;
            transient_out <= '0;
            timeout_out   <= 1'b1;
            done_out      <= 1'b1;
            busy_out      <= 1'b0;
            r_state       <= DONE;
        end else begin
            if (w_iter) begin
                r_steps <= r_steps + 32'd1;
            end
            case (r_state)
                LOAD: begin
                    r_tort  <= r_x0;
                    r_hare  <= w_next_a;
                    r_power <= 32'd1;
                    r_lam   <= 32'd1;
                    r_state <= LAM;
                end
                LAM: begin
                    if (r_tort == r_hare) begin
                        r_tort    <= r_x0;
                        r_hare    <= r_x0;
                        r_adv_cnt <= r_lam;
                        r_state   <= ADV;
                    end else if (r_power == r_lam) begin
                        r_tort  <= r_hare;
                        r_power <= r_power << 1;
                        r_lam   <= 32'd1;
                        r_hare  <= w_next_b;
                    end else begin
                        r_lam  <= r_lam + 32'd1;
                        r_hare <= w_next_b;
                    end
                end
                ADV: begin
                    if (r_adv_cnt == 32'd0) begin
                        r_mu    <= '0;
                        r_state <= MU;
                    end else begin
                        r_hare    <= w_next_b;
                        r_adv_cnt <= r_adv_cnt - 32'd1;
                    end
                end
                MU: begin
                    if (r_tort == r_hare) begin
                        length_out    <= r_lam;
                        transient_out <= r_mu;
                        done_out      <= 1'b1;
                        busy_out      <= 1'b0;
                        r_state       <= DONE;
                    end else begin
                        r_tort <= w_next_a;
                        r_hare <= w_next_b;
                        r_mu   <= r_mu + 32'd1;
                    end
                end
                DONE: begin
                    if (done_in) begin
                        done_out <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

endmodule

// File: tb/tb_grn_attractor_worker.sv
// Directed bench: three 4-node workers (rule 90, rotate-left, rotate-left with a tiny watchdog).
module tb_grn_attractor_worker;
    import grn_pkg::*;

    logic        clk;
    logic        rst;
    logic        r_start   [3];
    logic        r_done_in [3];
    logic [3:0]  r_conf    [3];
    logic [3:0]  w_conf    [3];
    logic [31:0] w_len     [3];
    logic [31:0] w_mu      [3];
    logic        w_done    [3];
    logic        w_busy    [3];
    logic        w_tmo     [3];

    int n_checks;
    int n_errors;

    grn_attractor_worker #(.VECTOR_SIZE(4), .RULE(RULE_RULE90), .MAX_STEPS(1024)) dut_r90 (
        .clk(clk), .rst(rst), .start_in(r_start[0]), .done_in(r_done_in[0]),
        .conf_in(r_conf[0]), .conf_out(w_conf[0]), .length_out(w_len[0]),
        .transient_out(w_mu[0]), .done_out(w_done[0]), .busy_out(w_busy[0]),
        .timeout_out(w_tmo[0])
    );

    grn_attractor_worker #(.VECTOR_SIZE(4), .RULE(RULE_ROTL), .MAX_STEPS(1024)) dut_rot (
        .clk(clk), .rst(rst), .start_in(r_start[1]), .done_in(r_done_in[1]),
        .conf_in(r_conf[1]), .conf_out(w_conf[1]), .length_out(w_len[1]),
        .transient_out(w_mu[1]), .done_out(w_done[1]), .busy_out(w_busy[1]),
        .timeout_out(w_tmo[1])
    );

    grn_attractor_worker #(.VECTOR_SIZE(4), .RULE(RULE_ROTL), .MAX_STEPS(3)) dut_wd (
        .clk(clk), .rst(rst), .start_in(r_start[2]), .done_in(r_done_in[2]),
        .conf_in(r_conf[2]), .conf_out(w_conf[2]), .length_out(w_len[2]),
        .transient_out(w_mu[2]), .done_out(w_done[2]), .busy_out(w_busy[2]),
        .timeout_out(w_tmo[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        logic [3:0]  conf;
        logic [31:0] len;
        logic [31:0] mu;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int d, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (w_done[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("done_seen[%0d]", d), {31'd0, ok}, 32'd1);
    endtask

    task automatic run_job(input int d, input logic [3:0] c);
        @(negedge clk);
        r_start[d] = 1'b1;
        r_conf[d]  = c;
        @(negedge clk);
        r_start[d] = 1'b0;
        wait_done(d, 32);
    endtask

    task automatic release_job(input int d);
        @(negedge clk);
        r_done_in[d] = 1'b1;
        @(negedge clk);
        r_done_in[d] = 1'b0;
        check($sformatf("released_done[%0d]", d), {31'd0, w_done[d]}, 32'd0);
        check($sformatf("released_busy[%0d]", d), {31'd0, w_busy[d]}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_conf[%0d]", tag, d), {28'd0, w_conf[d]}, 32'd0);
            check($sformatf("%s_len[%0d]", tag, d), w_len[d], 32'd0);
            check($sformatf("%s_mu[%0d]", tag, d), w_mu[d], 32'd0);
            check($sformatf("%s_flags[%0d]", tag, d),
                  {29'd0, w_done[d], w_busy[d], w_tmo[d]}, 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            r_start[d]   = 1'b0;
            r_done_in[d] = 1'b0;
            r_conf[d]    = 4'h0;
        end

        vecs[0] = '{dut: 0, conf: 4'h1, len: 32'd1, mu: 32'd2};
        vecs[1] = '{dut: 1, conf: 4'h1, len: 32'd4, mu: 32'd0};
        vecs[2] = '{dut: 1, conf: 4'h5, len: 32'd2, mu: 32'd0};
        vecs[3] = '{dut: 1, conf: 4'hF, len: 32'd1, mu: 32'd0};
        vecs[4] = '{dut: 0, conf: 4'h3, len: 32'd1, mu: 32'd2};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i].dut, vecs[i].conf);
            check($sformatf("v%0d_len", i), w_len[vecs[i].dut], vecs[i].len);
            check($sformatf("v%0d_mu", i), w_mu[vecs[i].dut], vecs[i].mu);
            check($sformatf("v%0d_conf", i), {28'd0, w_conf[vecs[i].dut]}, {28'd0, vecs[i].conf});
            check($sformatf("v%0d_tmo", i), {31'd0, w_tmo[vecs[i].dut]}, 32'd0);
            release_job(vecs[i].dut);
        end

        // Restart from DONE with start and done_in together: start must win.
        run_job(0, 4'h1);
        @(negedge clk);
        r_start[0]   = 1'b1;
        r_done_in[0] = 1'b1;
        r_conf[0]    = 4'h0;
        @(negedge clk);
        r_start[0]   = 1'b0;
        r_done_in[0] = 1'b0;
        check("b2b_done_low", {31'd0, w_done[0]}, 32'd0);
        check("b2b_busy", {31'd0, w_busy[0]}, 32'd1);
        wait_done(0, 32);
        check("b2b_len", w_len[0], 32'd1);
        check("b2b_mu", w_mu[0], 32'd0);
        check("b2b_conf", {28'd0, w_conf[0]}, 32'd0);
        release_job(0);

        // start_in during LAM must not restart the job.
        @(negedge clk);
        r_start[1] = 1'b1;
        r_conf[1]  = 4'h1;
        @(negedge clk);
        r_start[1] = 1'b0;
        @(negedge clk);
        r_start[1] = 1'b1;
        r_conf[1]  = 4'h5;
        @(negedge clk);
        r_start[1] = 1'b0;
        check("ignore_busy", {31'd0, w_busy[1]}, 32'd1);
        wait_done(1, 32);
        check("ignore_len", w_len[1], 32'd4);
        check("ignore_conf", {28'd0, w_conf[1]}, 32'd1);
        release_job(1);

        // done_in in IDLE: no effect, last result retained.
        @(negedge clk);
        r_done_in[1] = 1'b1;
        @(negedge clk);
        r_done_in[1] = 1'b0;
        @(negedge clk);
        check("idle_done_in_done", {31'd0, w_done[1]}, 32'd0);
        check("idle_done_in_busy", {31'd0, w_busy[1]}, 32'd0);
        check("idle_retain_len", w_len[1], 32'd4);
        check("idle_retain_conf", {28'd0, w_conf[1]}, 32'd1);

        // Watchdog.
        run_job(2, 4'h1);
        check("wd_tmo", {31'd0, w_tmo[2]}, 32'd1);
        check("wd_len", w_len[2], 32'd0);
        check("wd_mu", w_mu[2], 32'd0);
        check("wd_conf", {28'd0, w_conf[2]}, 32'd1);
        @(negedge clk);
        r_start[2] = 1'b1;
        r_conf[2]  = 4'hF;
        @(negedge clk);
        r_start[2] = 1'b0;
        check("wd_tmo_cleared", {31'd0, w_tmo[2]}, 32'd0);
        check("wd_restart_done_low", {31'd0, w_done[2]}, 32'd0);
        wait_done(2, 32);
        release_job(2);

        // Asynchronous reset while ROTL job 4'h5 sits in MU (8 edges after acceptance).
        @(negedge clk);
        r_start[1] = 1'b1;
        r_conf[1]  = 4'h5;
        @(posedge clk);
        #1 r_start[1] = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", {31'd0, w_busy[1]}, 32'd1);
        check("pre_rst_conf", {28'd0, w_conf[1]}, 32'd5);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", {31'd0, w_busy[1]}, 32'd0);
        check("post_rst_done", {31'd0, w_done[1]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
